// File: rtl/pu_pkg.sv
// ----------------------------------------------------------------------------
// pu_pkg
// Shared definitions for the PU data memory / network interface slice.
//   flow_t          : flit flow code carried in the top two bits of a flit
//   flit_t          : flit layout template {flow, payload} for 16-bit payloads
//   flits_per_word  : number of flit lanes in one memory word
//   ptr_width       : width of a flit pointer addressing every lane in memory
// ----------------------------------------------------------------------------
package pu_pkg;

    typedef enum logic [1:0] {
        FLOW_IDLE = 2'b00,
        FLOW_HEAD = 2'b01,
        FLOW_BODY = 2'b10,
        FLOW_TAIL = 2'b11
    } flow_t;

    localparam int FLIT_W_DEFAULT = 16;

    // Reference layout; parametrised modules slice the same shape by hand.
    typedef struct packed {
        flow_t                     flow;
        logic [FLIT_W_DEFAULT-1:0] payload;
    } flit_t;

    function automatic int flits_per_word(input int dataW, input int flitW);
        return dataW / flitW;
    endfunction

    function automatic int ptr_width(input int addrW, input int f);
        return addrW + $clog2(f);
    endfunction

endpackage

// File: rtl/dmem_nic_tx.sv
// ----------------------------------------------------------------------------
// dmem_nic_tx
// Transmit side of the data-memory NIC: turns a SEND request into a packet
// HEAD, len*F BODY flits read live from memory, then TAIL, with router
// backpressure on every flit.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   send_i          start request (ignored and flagged while busy)
//   ad_i            start word address
//   len_i           length in words
//   port_i          destination port placed in the HEAD payload
//   tx_ready_i      router accepts the current flit
//   lane_data_i     memory lane addressed by lane_ptr_o (combinational)
//   lane_ptr_o      flit pointer of the next BODY lane to load
//   tx_o            registered outgoing flit {flow, payload}
//   tx_busy_o       transfer in progress
//   send_err_o      one-cycle pulse after a send issued while busy
// ----------------------------------------------------------------------------
module dmem_nic_tx
    import pu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int FLIT_W = 16,
    parameter int PORT_W = 2,
    parameter int F      = 2,
    parameter int PTR_W  = ptr_width(ADDR_W, F)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_i,
    input  logic [ADDR_W-1:0] ad_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [PORT_W-1:0] port_i,
    input  logic              tx_ready_i,
    input  logic [FLIT_W-1:0] lane_data_i,
    output logic [PTR_W-1:0]  lane_ptr_o,
    output logic [FLIT_W+1:0] tx_o,
    output logic              tx_busy_o,
    output logic              send_err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;
    localparam logic [1:0] ST_TAIL = 2'd3;

    // Two extra bits so len*F never overflows the count register.
    localparam int              CNT_W    = PTR_W + 2;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'((2 ** ADDR_W) * F - 1);
    localparam logic [CNT_W-1:0] F_CNT    = CNT_W'(F);

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FLIT_W+1:0] tx_q, tx_d;
    logic              sendErr_q, sendErr_d;
    logic              accept;

    // addr/cnt describe the next lane still to be loaded into tx, so each
    // accepted flit fetches its successor from memory at that very edge.
    // This keeps tx registered while still seeing stores made mid-transfer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        sendErr_d = 1'b0;
        accept    = (tx_q[FLIT_W+1:FLIT_W] != FLOW_IDLE) && tx_ready_i;

        case (state_q)
            ST_IDLE: begin
                if (send_i) begin
                    state_d = ST_HEAD;
                    addr_d  = PTR_W'(ad_i) * PTR_W'(F);
                    cnt_d   = CNT_W'(len_i) * F_CNT;
                    tx_d    = {FLOW_HEAD, FLIT_W'(port_i)};
                end
            end
            ST_HEAD, ST_BODY: begin
                sendErr_d = send_i;
                if (accept) begin
                    if (cnt_q != '0) begin
                        state_d = ST_BODY;
                        tx_d    = {FLOW_BODY, lane_data_i};
                        addr_d  = (addr_q == PTR_LAST) ? '0 : addr_q + 1'b1;
                        cnt_d   = cnt_q - 1'b1;
                    end else begin
                        state_d = ST_TAIL;
                        tx_d    = {FLOW_TAIL, {FLIT_W{1'b0}}};
                    end
                end
            end
            default: begin
                sendErr_d = send_i;
                if (accept) begin
                    state_d = ST_IDLE;
                    tx_d    = '0;
                end
            end
        endcase
    end

    // Reset aborts any transfer on the spot with an idle output flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            tx_q      <= '0;
            sendErr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            sendErr_q <= sendErr_d;
        end
    end

    assign lane_ptr_o = addr_q;
    assign tx_o       = tx_q;
    assign tx_busy_o  = (state_q != ST_IDLE);
    assign send_err_o = sendErr_q;

endmodule

// File: rtl/dmem_nic.sv
// ----------------------------------------------------------------------------
// dmem_nic
// PU data memory with an integrated network interface. Holds the memory
// array, the merged store/receive write port and the receive flit pointer;
// the transmitter lives in dmem_nic_tx.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   ad         load/store word address, also SEND start address
//   wd         store data; wd[ADDR_W:0] is the SEND length in words
//   we         store enable
//   send       start a transfer
//   port       destination port for SEND
//   rd         combinational read data mem[ad]
//   rx         incoming flit {flow, payload}
//   tx         registered outgoing flit
//   tx_ready   router accepts tx this cycle
//   tx_busy    transfer in progress
//   send_err   pulse: send while busy was ignored
//   rx_done    pulse: a TAIL flit was received
// Build option: define DMEM_NIC_RX_RESTART_EN to make every received HEAD
// flit rewind the receive pointer to RX_BASE.
// ----------------------------------------------------------------------------
module dmem_nic
    import pu_pkg::*;
#(
    parameter int PU_ID   = 0,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int FLIT_W  = 16,
    parameter int PORT_W  = 2,
    parameter int RX_BASE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ad,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    input  logic              send,
    input  logic [PORT_W-1:0] port,
    output logic [DATA_W-1:0] rd,
    input  logic [FLIT_W+1:0] rx,
    output logic [FLIT_W+1:0] tx,
    input  logic              tx_ready,
    output logic              tx_busy,
    output logic              send_err,
    output logic              rx_done
);

    localparam int               F         = flits_per_word(DATA_W, FLIT_W);
    localparam int               PTR_W     = ptr_width(ADDR_W, F);
    localparam int               DEPTH     = 2 ** ADDR_W;
    localparam logic [PTR_W-1:0] F_PTR     = PTR_W'(F);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH * F - 1);
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(RX_BASE * F);

    if ((DATA_W % FLIT_W) != 0 || PORT_W > FLIT_W || PU_ID < 0) begin : g_cfgCheck
        $error("dmem_nic PU %0d: DATA_W must be a multiple of FLIT_W and PORT_W <= FLIT_W", PU_ID);
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        rxFlow;
    logic              rxBody;
    logic [PTR_W-1:0]  rxPtr_q, rxPtr_d;
    logic [ADDR_W-1:0] rxWord;
    int                rxLane;
    logic              rxDone_q;

    logic [PTR_W-1:0]  txPtr;
    logic [ADDR_W-1:0] txWord;
    int                txLane;
    logic [FLIT_W-1:0] txLaneData;

    assign rd     = mem[ad];
    assign rxFlow = rx[FLIT_W+1:FLIT_W];
    assign rxBody = (rxFlow == FLOW_BODY);

    // Split the flat flit pointers into word address and lane index.
    always_comb begin
        rxWord     = ADDR_W'(rxPtr_q / F_PTR);
        rxLane     = int'(rxPtr_q % F_PTR);
        txWord     = ADDR_W'(txPtr / F_PTR);
        txLane     = int'(txPtr % F_PTR);
        txLaneData = mem[txWord][txLane*FLIT_W +: FLIT_W];
    end

    // The rx lane write is issued after the store so that, when both hit the
    // same word, the received payload wins its lane and wd fills the rest.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[ad] <= wd;
        end
        if (rxBody) begin
            mem[rxWord][rxLane*FLIT_W +: FLIT_W] <= rx[FLIT_W-1:0];
        end
    end

    // Receive pointer advances per BODY flit and wraps over the whole memory.
    always_comb begin
        rxPtr_d = rxPtr_q;
`ifdef DMEM_NIC_RX_RESTART_EN
        if (rxFlow == FLOW_HEAD) begin
            rxPtr_d = PTR_RESET;
        end else if (rxBody) begin
            rxPtr_d = (rxPtr_q == PTR_LAST) ? '0 : rxPtr_q + 1'b1;
        end
`else
        if (rxBody) begin
            rxPtr_d = (rxPtr_q == PTR_LAST) ? '0 : rxPtr_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxPtr_q  <= PTR_RESET;
            rxDone_q <= 1'b0;
        end else begin
            rxPtr_q  <= rxPtr_d;
            rxDone_q <= (rxFlow == FLOW_TAIL);
        end
    end

    assign rx_done = rxDone_q;

    dmem_nic_tx #(
        .ADDR_W (ADDR_W),
        .FLIT_W (FLIT_W),
        .PORT_W (PORT_W),
        .F      (F),
        .PTR_W  (PTR_W)
    ) u_tx (
        .clk         (clk),
        .rst         (rst),
        .send_i      (send),
        .ad_i        (ad),
        .len_i       (wd[ADDR_W:0]),
        .port_i      (port),
        .tx_ready_i  (tx_ready),
        .lane_data_i (txLaneData),
        .lane_ptr_o  (txPtr),
        .tx_o        (tx),
        .tx_busy_o   (tx_busy),
        .send_err_o  (send_err)
    );

endmodule
